// File: rtl/ddram_arb_pkg.sv
// Shared types and helpers for the multi-channel DDRAM read arbiter.
package ddram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LOAD} arb_state_t;

  localparam int DDRAM_AW = 29;
  localparam int MAX_CH   = 8;

  // One-hot grant: the first requester found searching upward from ptr+1 (mod nch).
  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                input logic [2:0] ptr, input int nch);
    logic [MAX_CH-1:0] gnt;
    int idx;
    gnt = '0;
    for (int k = MAX_CH; k >= 1; k--) begin
      if (k <= nch) begin
        idx = int'(ptr) + k;
        if (idx >= nch) idx = idx - nch;
        if (req[idx[2:0]]) begin
          gnt = '0;
          gnt[idx[2:0]] = 1'b1;
        end
      end
    end
    return gnt;
  endfunction
endpackage

// File: rtl/ddram_multi_arbiter_if.sv
// Physical DDRAM command/data bus as seen by the arbiter (master) and the memory (slave).
interface ddram_multi_arbiter_if import ddram_arb_pkg::*; #(parameter int AW = DDRAM_AW);
  logic          ddram_rd;
  logic          ddram_we;
  logic [AW-1:0] ddram_addr;
  logic [63:0]   ddram_din;
  logic [7:0]    ddram_be;
  logic [63:0]   ddram_dout;
  logic          ddram_busy;
  logic          ddram_dout_ready;

  modport master (output ddram_rd, ddram_we, ddram_addr, ddram_din, ddram_be,
                  input  ddram_dout, ddram_busy, ddram_dout_ready);
  modport slave  (input  ddram_rd, ddram_we, ddram_addr, ddram_din, ddram_be,
                  output ddram_dout, ddram_busy, ddram_dout_ready);
endinterface

// File: rtl/ddram_line_buf.sv
// One-line (64-bit) hit buffer for a single read channel: tag, valid and data.
module ddram_line_buf import ddram_arb_pkg::*; #(parameter int AW = DDRAM_AW) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_tag,
  input  logic [63:0]   wr_data,
  input  logic          inv_en,
  input  logic [AW-1:0] inv_addr,
  input  logic          clr_all,
  input  logic [AW-1:0] cmp_addr,
  output logic          hit,
  output logic [63:0]   data
);
  logic          valid;
  logic [AW-1:0] tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end else if (clr_all || (inv_en && inv_addr == tag)) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (cmp_addr == tag);
endmodule

// File: rtl/ddram_multi_arbiter.sv
// N-channel DDRAM read arbiter with per-channel line buffers and a loader write passthrough.
module ddram_multi_arbiter import ddram_arb_pkg::*; #(
  parameter int NCH = 3,
  parameter int AW  = DDRAM_AW,
  parameter int RR  = 1
) (
  input  logic                  fixed_50m_clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        req,
  input  logic [NCH*AW-1:0]     req_addr,
  output logic [NCH-1:0]        ack,
  output logic [63:0]           rsp_data,
  input  logic                  ld_active,
  input  logic                  ld_wr,
  input  logic [AW-1:0]         ld_addr,
  input  logic [63:0]           ld_din,
  input  logic [7:0]            ld_be,
  output logic                  ld_ready,
  ddram_multi_arbiter_if.master ddram
);
  localparam int IW = $clog2(NCH);

  arb_state_t           state, nstate;
  logic [IW-1:0]        ptr, win_q, gnt_idx;
  logic [AW-1:0]        addr_q, gnt_addr;
  logic [NCH-1:0]       gnt, hit;
  logic [NCH-1:0][63:0] buf_data;
  logic                 gnt_hit, ld_acc, rd_done;

  // Fixed priority reuses the rotating search with the pointer pinned to the last channel.
  always_comb begin
    gnt     = NCH'(rr_pick(MAX_CH'(req), (RR != 0) ? 3'(ptr) : 3'(NCH-1), NCH));
    gnt_idx = '0;
    for (int i = 0; i < NCH; i++)
      if (gnt[i]) gnt_idx = IW'(i);
    gnt_addr = req_addr[gnt_idx*AW +: AW];
    gnt_hit  = |(gnt & hit);
  end

  assign rd_done = (state == WAIT) && ddram.ddram_dout_ready;
  assign ld_acc  = (state == LOAD) && ld_wr && !ddram.ddram_busy;

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (ld_active) nstate = LOAD;
               else if (|gnt && !gnt_hit) nstate = ISSUE;
      ISSUE:   if (!ddram.ddram_busy) nstate = WAIT;
      WAIT:    if (ddram.ddram_dout_ready) nstate = IDLE;
      LOAD:    if (!ld_active) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge fixed_50m_clk) begin
    if (reset) begin
      state    <= IDLE;
      ack      <= '0;
      rsp_data <= '0;
      ptr      <= IW'(NCH-1);
      win_q    <= '0;
      addr_q   <= '0;
    end else begin
      state <= nstate;
      ack   <= '0;
      if (state == IDLE && !ld_active && |gnt) begin
        ptr <= gnt_idx;
        if (gnt_hit) begin
          ack      <= gnt;
          rsp_data <= buf_data[gnt_idx];
        end else begin
          win_q  <= gnt_idx;
          addr_q <= gnt_addr;
        end
      end
      if (rd_done) begin
        ack[win_q] <= 1'b1;
        rsp_data   <= ddram.ddram_dout;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_buf
    ddram_line_buf #(.AW(AW)) u_buf (
      .clk      (fixed_50m_clk),
      .reset    (reset),
      .wr_en    (rd_done && win_q == IW'(i)),
      .wr_tag   (addr_q),
      .wr_data  (ddram.ddram_dout),
      .inv_en   (ld_acc),
      .inv_addr (ld_addr),
      .clr_all  (state == IDLE && ld_active),
      .cmp_addr (req_addr[i*AW +: AW]),
      .hit      (hit[i]),
      .data     (buf_data[i])
    );
  end

  assign ddram.ddram_rd   = (state == ISSUE);
  assign ddram.ddram_we   = ld_acc;
  assign ddram.ddram_addr = (state == LOAD) ? ld_addr : addr_q;
  assign ddram.ddram_din  = (state == LOAD) ? ld_din : '0;
  assign ddram.ddram_be   = (state == LOAD) ? ld_be : 8'hFF;
  assign ld_ready         = (state == LOAD) && !ddram.ddram_busy;
endmodule

// File: tb/tb_ddram_multi_arbiter.sv
// Scoreboard bench: instance 0 round-robin, instance 1 fixed priority, shared loader and reset.
module tb_ddram_multi_arbiter;
  localparam int NCH = 3, AW = 29, NI = 2, LAT = 2;

  typedef struct { int ch; logic [63:0] data; } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  always #10 clk = ~clk;

  logic [NI-1:0][NCH-1:0]    req, ack;
  logic [NI-1:0][NCH*AW-1:0] req_addr;
  logic [NI-1:0][63:0]       rsp_data;
  logic [NI-1:0]             ld_ready;
  logic [NI-1:0]             busy = '0;
  logic                      ld_active = 1'b0, ld_wr = 1'b0;
  logic [AW-1:0]             ld_addr = '0;
  logic [63:0]               ld_din = '0;
  logic [7:0]                ld_be = '0;

  logic [AW-1:0] cq[NI*NCH][$];
  exp_t          exp_q[NI][$];
  int            n_chk = 0, n_fail = 0;

  ddram_multi_arbiter_if #(.AW(AW)) bus [NI] ();

  function automatic logic [63:0] mem_data(input logic [AW-1:0] a);
    return (a == AW'(32'h100)) ? 64'hDEADBEEF_01234567 : {16'hC0DE, 19'd0, a};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    int            cd = 0, rd_cnt = 0;
    logic [AW-1:0] pa = '0;

    ddram_multi_arbiter #(.NCH(NCH), .AW(AW), .RR(g == 0 ? 1 : 0)) dut (
      .fixed_50m_clk (clk),
      .reset         (rst),
      .req           (req[g]),
      .req_addr      (req_addr[g]),
      .ack           (ack[g]),
      .rsp_data      (rsp_data[g]),
      .ld_active     (ld_active),
      .ld_wr         (ld_wr),
      .ld_addr       (ld_addr),
      .ld_din        (ld_din),
      .ld_be         (ld_be),
      .ld_ready      (ld_ready[g]),
      .ddram         (bus[g])
    );

    assign bus[g].ddram_busy = busy[g];

    // Memory model: data returns LAT+1 cycles after the accepted read; unaffected by reset.
    always @(posedge clk) begin
      bus[g].ddram_dout_ready <= 1'b0;
      if (bus[g].ddram_rd === 1'b1 && !busy[g]) begin
        cd     <= LAT;
        pa     <= bus[g].ddram_addr;
        rd_cnt <= rd_cnt + 1;
      end else if (cd > 1) begin
        cd <= cd - 1;
      end else if (cd == 1) begin
        cd <= 0;
        bus[g].ddram_dout_ready <= 1'b1;
        bus[g].ddram_dout       <= mem_data(pa);
      end
    end
  end

  // Clients: present queue head, move to the next entry in the ack cycle.
  always @(negedge clk) begin
    for (int k = 0; k < NI*NCH; k++) begin
      if (ack[k/NCH][k%NCH] === 1'b1 && cq[k].size() > 0) void'(cq[k].pop_front());
      req[k/NCH][k%NCH] <= (cq[k].size() > 0);
      req_addr[k/NCH][(k%NCH)*AW +: AW] <= (cq[k].size() > 0) ? cq[k][0] : '0;
    end
  end

  // Monitor: every ack pops the expected channel/data.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++)
      for (int i = 0; i < NCH; i++)
        if (ack[g][i] === 1'b1) begin
          n_chk++;
          if (exp_q[g].size() == 0) begin
            n_fail++;
            $display("FAIL ack_unexpected inst%0d: actual ack ch %0d, required none", g, i);
          end else begin
            exp_t e;
            e = exp_q[g].pop_front();
            if (e.ch != i || rsp_data[g] !== e.data) begin
              n_fail++;
              $display("FAIL ack_data inst%0d: actual ch %0d data %h, required ch %0d data %h",
                       g, i, rsp_data[g], e.ch, e.data);
            end
          end
        end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp_v);
    end
  endtask

  task automatic rq(input int g, input int ch, input logic [AW-1:0] a, input bit with_ack);
    exp_t e;
    cq[g*NCH+ch].push_back(a);
    if (with_ack) begin
      e.ch = ch;
      e.data = mem_data(a);
      exp_q[g].push_back(e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (exp_q[g].size() != 0 && n < 300) begin cyc(1); n++; end
    n_chk++;
    if (exp_q[g].size() != 0) begin
      n_fail++;
      $display("FAIL timeout inst%0d: actual %0d acks outstanding, required 0", g, exp_q[g].size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ack"},      64'(ack[0]), 64'd0);
    chk({tag, "_rsp"},      rsp_data[0], 64'd0);
    chk({tag, "_rd"},       64'(bus[0].ddram_rd), 64'd0);
    chk({tag, "_we"},       64'(bus[0].ddram_we), 64'd0);
    chk({tag, "_addr"},     64'(bus[0].ddram_addr), 64'd0);
    chk({tag, "_ld_ready"}, 64'(ld_ready[0]), 64'd0);
    chk({tag, "_be"},       64'(bus[0].ddram_be), 64'hFF);
  endtask

  initial begin
    int prev;
    cyc(1);
    chk_reset_outs("reset");
    cyc(1);
    rst = 1'b0;

    // Single miss then hit on the same line
    rq(0, 0, AW'(32'h100), 1'b1);
    cyc(1);
    chk("miss_rd", 64'(bus[0].ddram_rd), 64'd1);
    chk("miss_addr", 64'(bus[0].ddram_addr), 64'h100);
    wait_idle(0);
    chk("miss_rd_count", 64'(g_inst[0].rd_cnt), 64'd1);
    rq(0, 0, AW'(32'h100), 1'b1);
    cyc(1);
    chk("hit_ack_t1", 64'(ack[0]), 64'b001);
    chk("hit_no_rd", 64'(bus[0].ddram_rd), 64'd0);
    wait_idle(0);
    chk("hit_rd_count", 64'(g_inst[0].rd_cnt), 64'd1);

    // Round-robin on inst0 (0,1,2,0) and fixed priority on inst1 (0,0,0,1)
    do_reset();
    rq(0, 0, AW'(32'h200), 1'b1);
    rq(0, 1, AW'(32'h300), 1'b1);
    rq(0, 2, AW'(32'h400), 1'b1);
    rq(0, 0, AW'(32'h210), 1'b1);
    rq(1, 0, AW'(32'h500), 1'b1);
    rq(1, 1, AW'(32'h600), 1'b0);
    rq(1, 0, AW'(32'h510), 1'b1);
    rq(1, 0, AW'(32'h520), 1'b1);
    begin exp_t e; e.ch = 1; e.data = mem_data(AW'(32'h600)); exp_q[1].push_back(e); end
    wait_idle(0);
    wait_idle(1);
    chk("rr_rd_count", 64'(g_inst[0].rd_cnt), 64'd5);

    // Busy stall: rd held while busy, one acceptance
    busy[0] = 1'b1;
    rq(0, 1, AW'(32'h700), 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_rd_high", 64'(bus[0].ddram_rd), 64'd1);
    end
    busy[0] = 1'b0;
    cyc(1);
    chk("stall_rd_drop", 64'(bus[0].ddram_rd), 64'd0);
    chk("stall_one_accept", 64'(g_inst[0].rd_cnt), 64'd6);
    wait_idle(0);

    // Loader rising in WAIT is deferred until the read completes
    rq(0, 2, AW'(32'h800), 1'b1);
    cyc(2);
    ld_active = 1'b1;
    wait_idle(0);
    cyc(1);
    chk("load_ld_ready", 64'(ld_ready[0]), 64'd1);

    // Passthrough; requests during LOAD get no ack until it ends
    rq(0, 0, AW'(32'h900), 1'b0);
    ld_wr = 1'b1; ld_addr = AW'(32'h40); ld_din = 64'h1122334455667788; ld_be = 8'h0C;
    #1;
    chk("load_we", 64'(bus[0].ddram_we), 64'd1);
    chk("load_addr", 64'(bus[0].ddram_addr), 64'h40);
    chk("load_be", 64'(bus[0].ddram_be), 64'h0C);
    chk("load_din", bus[0].ddram_din, 64'h1122334455667788);
    busy[0] = 1'b1;
    #1;
    chk("load_busy_we", 64'(bus[0].ddram_we), 64'd0);
    chk("load_busy_ready", 64'(ld_ready[0]), 64'd0);
    busy[0] = 1'b0;
    ld_addr = AW'(32'h800);
    cyc(4);
    ld_wr = 1'b0;
    ld_active = 1'b0;
    begin exp_t e; e.ch = 0; e.data = mem_data(AW'(32'h900)); exp_q[0].push_back(e); end
    wait_idle(0);
    prev = g_inst[0].rd_cnt;
    rq(0, 2, AW'(32'h800), 1'b1);
    wait_idle(0);
    chk("post_load_miss", 64'(g_inst[0].rd_cnt), 64'(prev + 1));

    // Reset while waiting for data: no ack, reset outputs, buffers invalid
    rq(0, 1, AW'(32'hA00), 1'b0);
    cyc(2);
    rst = 1'b1;
    cq[1].delete();
    cyc(1);
    rst = 1'b0;
    chk_reset_outs("rst_wait");
    cyc(5);
    chk("rst_wait_rsp_kept", rsp_data[0], 64'd0);
    prev = g_inst[0].rd_cnt;
    rq(0, 0, AW'(32'h900), 1'b1);
    wait_idle(0);
    chk("rst_buf_invalid", 64'(g_inst[0].rd_cnt), 64'(prev + 1));

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400us;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
